// File: rtl/cnn_mem_arbiter_if.sv
// cnn_mem_arbiter_if: core, loader and memory-side signals of the CNN memory arbiter
// slave  : arbiter view (requests and memory responses in; data, strobes, grant, err out)
// master : system view (cores, loader and memory model drive the opposite directions)
interface cnn_mem_arbiter_if;
   logic        core_req, core_we, core_ready;
   logic [11:0] core_addr;
   logic [15:0] core_wdata, core_rdata;
   logic        dma_req, dma_we, dma_ready;
   logic [11:0] dma_addr;
   logic [15:0] dma_wdata, dma_rdata;
   logic        mem_req, mem_we, mem_ready;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [1:0]  grant;
   logic        err;
   modport slave (
      input  core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata,
             mem_rdata, mem_ready,
      output core_rdata, core_ready, dma_rdata, dma_ready, mem_req, mem_we, mem_addr, mem_wdata,
             grant, err
   );
   modport master (
      output core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata,
             mem_rdata, mem_ready,
      input  core_rdata, core_ready, dma_rdata, dma_ready, mem_req, mem_we, mem_addr, mem_wdata,
             grant, err
   );
endinterface

// File: rtl/cnn_mem_arbiter.sv
// cnn_mem_arbiter: round-robin arbiter between CNN core and DMA loader for one memory port
// clk, rst : clock, asynchronous active-high reset
// bus      : core_*/dma_* request ports with registered rdata and ready pulses,
//            mem_* memory strobe/response, grant (01 core, 10 dma), err (timeout abort)
module cnn_mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst,
   cnn_mem_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t        state, state_n;
   logic          last_dma, we_q, core_el, dma_el, pick_core, done;
   logic [CW-1:0] cnt;
   // a port whose ready pulse is showing this cycle is not eligible, so a held req cannot re-win at once
   always_comb begin
      core_el   = bus.core_req & ~bus.core_ready;
      dma_el    = bus.dma_req & ~bus.dma_ready;
      pick_core = core_el & (~dma_el | last_dma);
      done      = bus.mem_ready | (cnt == CW'(TIMEOUT - 1));
      state_n   = state == IDLE ? ((core_el | dma_el) ? ACCESS : IDLE) : (done ? IDLE : ACCESS);
   end
   always_comb begin
      bus.mem_req = state == ACCESS;
      bus.mem_we  = (state == ACCESS) && we_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= IDLE;
         bus.grant      <= 2'b00;
         last_dma       <= 1'b1;
         we_q           <= 1'b0;
         cnt            <= '0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.core_ready <= 1'b0;
         bus.dma_ready  <= 1'b0;
         bus.err        <= 1'b0;
         bus.core_rdata <= '0;
         bus.dma_rdata  <= '0;
      end else begin
         state          <= state_n;
         bus.core_ready <= 1'b0;
         bus.dma_ready  <= 1'b0;
         bus.err        <= 1'b0;
         if (state == IDLE && state_n == ACCESS) begin
            bus.grant     <= pick_core ? 2'b01 : 2'b10;
            last_dma      <= ~pick_core;
            we_q          <= pick_core ? bus.core_we : bus.dma_we;
            bus.mem_addr  <= pick_core ? bus.core_addr : bus.dma_addr;
            bus.mem_wdata <= pick_core ? bus.core_wdata : bus.dma_wdata;
            cnt           <= '0;
         end else if (state == ACCESS) begin
            if (done) begin
               bus.grant      <= 2'b00;
               bus.core_ready <= bus.grant[0];
               bus.dma_ready  <= bus.grant[1];
               bus.err        <= ~bus.mem_ready;
               if (!we_q && bus.grant[0]) bus.core_rdata <= bus.mem_ready ? bus.mem_rdata : 16'hFFFF;
               if (!we_q && bus.grant[1]) bus.dma_rdata <= bus.mem_ready ? bus.mem_rdata : 16'hFFFF;
            end else
               cnt <= cnt + 1'b1;
         end
      end
endmodule
